// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, Z/N status flags and memory-indirect jump sequencer
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  input  logic        outmux1,
  input  logic        outmux0,
  input  logic        jbrnmux,
  input  logic        wrtdatmux,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr26,
  input  logic [31:0] rs_val,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        flag_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc,
  output logic        zout,
  output logic        nout,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        stall,
  output logic        fault
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_JM    = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Counter is 8 bits wide because TIMEOUT is limited to 1..255.
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] jm_addr_q, jm_addr_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        fault_q, fault_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] p4;
  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [7:0]  cnt_inc;
  logic        run_adv;

  assign p4        = pc_q + 32'd4;
  assign br_off    = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_target = p4 + br_off;
  assign j_target  = {p4[31:28], jaddr26, 2'b00};
  assign cnt_inc   = cnt_q + 8'd1;
  assign run_adv   = (state_q == ST_RUN) && adv;

  // Next-state, PC selection, flag update and jm wait/timeout tracking
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    jm_addr_d = jm_addr_q;
    z_d       = z_q;
    n_d       = n_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (adv) begin
          // Flags update at the edge; branch selects already used the old values.
          if (flag_we) begin
            z_d = alu_zero;
            n_d = alu_neg;
          end
          case ({outmux1, outmux0})
            2'b00: pc_d = p4;
            2'b11: pc_d = br_target;
            2'b01: pc_d = jbrnmux ? (rs_val & ~32'h3) : j_target;
            default: begin
              // Memory-indirect jump: capture the pointer, PC waits for the load.
              state_d   = ST_JM;
              jm_addr_d = rs_val & ~32'h3;
              cnt_d     = 8'd0;
            end
          endcase
        end
      end
      ST_JM: begin
        // An ack in the same cycle the count expires still completes the jump.
        if (mem_ack) begin
          pc_d    = mem_rdata & ~32'h3;
          cnt_d   = 8'd0;
          state_d = ST_RUN;
        end else if (cnt_inc == TMO) begin
          cnt_d   = cnt_inc;
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      jm_addr_q <= 32'd0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      jm_addr_q <= jm_addr_d;
      z_q       <= z_d;
      n_q       <= n_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign zout      = z_q;
  assign nout      = n_q;
  assign link_we   = run_adv && wrtdatmux;
  assign link_data = p4;
  assign mem_req   = (state_q == ST_JM);
  assign mem_addr  = (state_q == ST_JM) ? jm_addr_q : 32'd0;
  assign stall     = (state_q != ST_RUN);
  assign fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer with a behavioural model
module tb_pc_sequencer;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        adv;
  logic        outmux1;
  logic        outmux0;
  logic        jbrnmux;
  logic        wrtdatmux;
  logic [15:0] imm16;
  logic [25:0] jaddr26;
  logic [31:0] rs_val;
  logic        alu_zero;
  logic        alu_neg;
  logic        flag_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] pc;
  logic        zout;
  logic        nout;
  logic        link_we;
  logic [31:0] link_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        stall;
  logic        fault;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_z, m_n;
  bit          m_jm, m_fault;
  logic [31:0] m_ptr;
  int          m_wait;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .adv(adv), .outmux1(outmux1), .outmux0(outmux0),
    .jbrnmux(jbrnmux), .wrtdatmux(wrtdatmux), .imm16(imm16), .jaddr26(jaddr26),
    .rs_val(rs_val), .alu_zero(alu_zero), .alu_neg(alu_neg), .flag_we(flag_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc), .zout(zout), .nout(nout),
    .link_we(link_we), .link_data(link_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .stall(stall), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one clock edge's worth of architectural behaviour to the model.
  task automatic model_next();
    logic [31:0] p4;
    if (!rst_n) begin
      m_pc = 32'h0; m_z = 0; m_n = 0; m_jm = 0; m_fault = 0; m_wait = 0;
    end else if (m_fault) begin
      // stuck until reset
    end else if (m_jm) begin
      if (mem_ack) begin
        m_pc = mem_rdata & ~32'h3; m_jm = 0; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin m_jm = 0; m_fault = 1; end
      end
    end else if (adv) begin
      p4 = m_pc + 32'd4;
      if (!outmux1 && !outmux0) m_pc = p4;
      else if (outmux1 && outmux0) m_pc = p4 + 32'(int'($signed(imm16)) * 4);
      else if (outmux0) m_pc = jbrnmux ? (rs_val & ~32'h3) : ((p4 & 32'hF000_0000) | (32'(jaddr26) * 4));
      else begin m_jm = 1; m_ptr = rs_val & ~32'h3; m_wait = 0; end
      if (flag_we) begin m_z = alu_zero; m_n = alu_neg; end
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1; adv = 0; outmux1 = 0; outmux0 = 0; jbrnmux = 0; wrtdatmux = 0;
    imm16 = 0; jaddr26 = 0; rs_val = 0; alu_zero = 0; alu_neg = 0; flag_we = 0;
    mem_rdata = 0; mem_ack = 0;
  endtask

  task automatic reg_jump(input logic [31:0] tgt);
    idle_inputs();
    adv = 1; outmux0 = 1; jbrnmux = 1; rs_val = tgt;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (zout !== 1'b0 || nout !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", zout, nout); end
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_ctl got stall=%b req=%b fault=%b want 000", stall, mem_req, fault); end
    checks++; if (link_we !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL reset_link got we=%b addr=%h want 0", link_we, mem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] want;
    idle_inputs();
    adv = 1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (link_we !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL seq_ctl got we=%b stall=%b want 0 0", link_we, stall); end
      tick();
      want = 32'(i * 4);
      checks++; if (pc !== want) begin errors++; $display("FAIL seq_pc got %h want %h", pc, want); end
    end
  endtask

  task automatic test_branch();
    reg_jump(32'h0000_00FC);
    adv = 1; flag_we = 1; alu_zero = 1; alu_neg = 0;
    tick();
    checks++; if (pc !== 32'h100 || zout !== 1'b1) begin errors++; $display("FAIL flag_set got pc=%h z=%b want 100 1", pc, zout); end
    idle_inputs();
    adv = 1; outmux1 = 1; outmux0 = 1; imm16 = 16'hFFFE;
    tick();
    checks++; if (pc !== 32'h0000_00FC) begin errors++; $display("FAIL branch_back got %h want %h", pc, 32'hFC); end
    // Branch and flag write in the same cycle: pre-edge flags stay visible until the edge.
    flag_we = 1; alu_zero = 0; alu_neg = 1; imm16 = 16'h0010;
    #1;
    checks++; if (zout !== 1'b1 || nout !== 1'b0) begin errors++; $display("FAIL flag_old got %b%b want 10", zout, nout); end
    tick();
    checks++; if (pc !== 32'h140 || zout !== 1'b0 || nout !== 1'b1) begin errors++; $display("FAIL branch_fwd got pc=%h zn=%b%b want 140 01", pc, zout, nout); end
  endtask

  task automatic test_jump();
    reg_jump(32'h2000_0000);
    adv = 1; outmux0 = 1; jbrnmux = 0; jaddr26 = 26'h000_0040;
    tick();
    checks++; if (pc !== 32'h2000_0100) begin errors++; $display("FAIL jump_direct got %h want %h", pc, 32'h2000_0100); end
    jbrnmux = 1; rs_val = 32'h0000_1233;
    tick();
    checks++; if (pc !== 32'h0000_1230) begin errors++; $display("FAIL jump_reg got %h want %h", pc, 32'h1230); end
  endtask

  task automatic test_link();
    reg_jump(32'h0000_0040);
    wrtdatmux = 1; outmux0 = 1; jaddr26 = 26'h123;
    #1;
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL link_noadv got %b want 0", link_we); end
    adv = 1;
    #1;
    checks++; if (link_we !== 1'b1 || link_data !== 32'h44) begin errors++; $display("FAIL link_we got we=%b data=%h want 1 44", link_we, link_data); end
    tick();
    checks++; if (pc !== 32'h0000_048C) begin errors++; $display("FAIL link_pc got %h want %h", pc, 32'h48C); end
  endtask

  task automatic test_jm_ack();
    logic z0, n0;
    reg_jump(32'h0000_0200);
    z0 = zout; n0 = nout;
    adv = 1; outmux1 = 1; rs_val = 32'h0000_0500;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      adv = 1; flag_we = 1; alu_zero = ~z0; alu_neg = ~n0; wrtdatmux = 1; rs_val = $urandom;
      mem_ack = (i == 2); mem_rdata = 32'h0000_0A03;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500 || stall !== 1'b1) begin errors++; $display("FAIL jm_wait%0d got req=%b addr=%h stall=%b want 1 500 1", i, mem_req, mem_addr, stall); end
      checks++; if (link_we !== 1'b0 || pc !== 32'h200) begin errors++; $display("FAIL jm_hold%0d got we=%b pc=%h want 0 200", i, link_we, pc); end
      tick();
    end
    idle_inputs();
    #1;
    checks++; if (pc !== 32'hA00 || stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL jm_done got pc=%h stall=%b req=%b want a00 0 0", pc, stall, mem_req); end
    checks++; if (zout !== z0 || nout !== n0) begin errors++; $display("FAIL jm_flags got %b%b want %b%b", zout, nout, z0, n0); end
  endtask

  task automatic test_ack_at_limit();
    reg_jump(32'h0000_0300);
    adv = 1; outmux1 = 1; rs_val = 32'h0000_0600;
    tick();
    idle_inputs();
    for (int i = 0; i < TMO; i++) begin
      mem_ack = (i == TMO - 1); mem_rdata = 32'h0000_7778;
      tick();
    end
    idle_inputs();
    checks++; if (pc !== 32'h7778 || fault !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL ack_at_limit got pc=%h fault=%b stall=%b want 7778 0 0", pc, fault, stall); end
  endtask

  task automatic test_timeout();
    int req_cycles;
    reg_jump(32'h0000_0400);
    adv = 1; outmux1 = 1; rs_val = 32'h0000_0500;
    tick();
    idle_inputs();
    req_cycles = 0;
    for (int i = 0; i < TMO + 4; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      tick();
    end
    checks++; if (req_cycles !== TMO) begin errors++; $display("FAIL timeout_req_cycles got %0d want %0d", req_cycles, TMO); end
    checks++; if (fault !== 1'b1 || stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_state got fault=%b stall=%b req=%b want 1 1 0", fault, stall, mem_req); end
    adv = 1; mem_ack = 1; mem_rdata = 32'h0000_1111;
    tick(); tick();
    checks++; if (pc !== 32'h400 || fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got pc=%h fault=%b want 400 1", pc, fault); end
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if (fault !== 1'b0 || stall !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL fault_clear got fault=%b stall=%b pc=%h want 0 0 0", fault, stall, pc); end
  endtask

  task automatic test_reset_mid_jm();
    reg_jump(32'h0000_0800);
    adv = 1; outmux1 = 1; rs_val = 32'h0000_0900;
    tick();
    idle_inputs();
    tick(); tick();
    rst_n = 0;
    tick();
    idle_inputs();
    checks++; if (pc !== 32'h0 || mem_req !== 1'b0 || fault !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_mid_jm got pc=%h req=%b fault=%b stall=%b want 0 0 0 0", pc, mem_req, fault, stall); end
    mem_ack = 1; mem_rdata = 32'h0000_0ABC;
    tick();
    idle_inputs();
    checks++; if (pc !== 32'h0 || stall !== 1'b0) begin errors++; $display("FAIL late_ack got pc=%h stall=%b want 0 0", pc, stall); end
  endtask

  task automatic test_random();
    bit exp_lwe;
    idle_inputs();
    rst_n = 0;
    tick();
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      adv       = $urandom_range(0, 3) != 0;
      outmux1   = $urandom_range(0, 1) == 1;
      outmux0   = $urandom_range(0, 1) == 1;
      jbrnmux   = $urandom_range(0, 1) == 1;
      wrtdatmux = $urandom_range(0, 1) == 1;
      imm16     = 16'($urandom);
      jaddr26   = 26'($urandom);
      rs_val    = $urandom;
      alu_zero  = $urandom_range(0, 1) == 1;
      alu_neg   = $urandom_range(0, 1) == 1;
      flag_we   = $urandom_range(0, 1) == 1;
      mem_rdata = $urandom;
      mem_ack   = $urandom_range(0, 9) == 0;
      #1;
      exp_lwe = !m_jm && !m_fault && adv && wrtdatmux;
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); end
      checks++; if (zout !== m_z || nout !== m_n) begin errors++; $display("FAIL rnd_flags cyc %0d got %b%b want %b%b", i, zout, nout, m_z, m_n); end
      checks++; if (stall !== (m_jm || m_fault) || mem_req !== m_jm || fault !== m_fault) begin errors++; $display("FAIL rnd_ctl cyc %0d got stall=%b req=%b fault=%b want %b %b %b", i, stall, mem_req, fault, m_jm || m_fault, m_jm, m_fault); end
      checks++; if (link_we !== exp_lwe || link_data !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_link cyc %0d got we=%b data=%h want %b %h", i, link_we, link_data, exp_lwe, m_pc + 32'd4); end
      if (m_jm) begin
        checks++; if (mem_addr !== m_ptr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, mem_addr, m_ptr); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = 0; m_z = 0; m_n = 0; m_jm = 0; m_fault = 0; m_ptr = 0; m_wait = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_link();
    test_jm_ack();
    test_ack_at_limit();
    test_timeout();
    test_reset_mid_jm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
